// File: rtl/button_event_gen.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// button_event_gen
//
// Button front-end for the watch. Each of the three raw push-buttons (config,
// increment, decrement) is synchronised, debounced and edge-detected, and
// turned into single-cycle event pulses for the watch edit logic. Increment
// and decrement also auto-repeat while held. Holding both of them at once
// locks both out until each has been released.
//
// Ports
//   clock          system clock
//   reset_i        asynchronous, active-low reset
//   config_i       raw config button, active-high, asynchronous
//   increment_i    raw increment button, active-high, asynchronous
//   decrement_i    raw decrement button, active-high, asynchronous
//   config_pulse_o one-cycle pulse per accepted config press
//   inc_pulse_o    one-cycle pulse per accepted increment press or repeat
//   dec_pulse_o    one-cycle pulse per accepted decrement press or repeat
//   btn_level_o    debounced levels {config, inc, dec}
// -----------------------------------------------------------------------------
module button_event_gen #(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int HOLD_CYCLES     = 50_000_000,
   parameter int REPEAT_CYCLES   = 10_000_000
) (
   input  logic       clock,
   input  logic       reset_i,
   input  logic       config_i,
   input  logic       increment_i,
   input  logic       decrement_i,
   output logic       config_pulse_o,
   output logic       inc_pulse_o,
   output logic       dec_pulse_o,
   output logic [2:0] btn_level_o
);

   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int TMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   // The debounce counter runs up to DEBOUNCE_CYCLES and commits on the
   // following mismatched cycle, giving a level change DEBOUNCE_CYCLES + 2
   // cycles after the raw edge is first sampled.
   localparam logic [DW-1:0] DB_LAST     = DW'(DEBOUNCE_CYCLES);
   localparam logic [TW-1:0] HOLD_LAST   = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] REPEAT_LAST = TW'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_HOLD,
      ST_REPEAT,
      ST_LOCK
   } rpt_state_t;

   // Bit order everywhere: 2 = config, 1 = inc, 0 = dec.
   logic [2:0] raw;
   logic [2:0] stable_vec;
   logic [2:0] rise_vec;
   logic       cfg_pulse;

   assign raw = {config_i, increment_i, decrement_i};

   for (genvar g = 0; g < 3; g++) begin : g_btn
      logic          sync_p0;
      logic          sync_p1;
      logic          stable_p2;
      logic          stable_p3;
      logic [DW-1:0] cnt;

      always_ff @(posedge clock or negedge reset_i) begin
         if (!reset_i) begin
            sync_p0   <= 1'b0;
            sync_p1   <= 1'b0;
            stable_p2 <= 1'b0;
            stable_p3 <= 1'b0;
            cnt       <= '0;
         end else begin
            // p0/p1: two-flop synchroniser
            sync_p0 <= raw[g];
            sync_p1 <= sync_p0;
            // p2: debounced level; any agreeing cycle restarts the count
            if (sync_p1 == stable_p2) begin
               cnt <= '0;
            end else if (cnt == DB_LAST) begin
               stable_p2 <= sync_p1;
               cnt       <= '0;
            end else begin
               cnt <= cnt + DW'(1);
            end
            // p3: previous debounced level, for edge detection
            stable_p3 <= stable_p2;
         end
      end

      assign stable_vec[g] = stable_p2;
      assign rise_vec[g]   = stable_p2 & ~stable_p3;
   end

   // Config only produces the press pulse, no auto-repeat.
   always_ff @(posedge clock or negedge reset_i) begin
      if (!reset_i) begin
         cfg_pulse <= 1'b0;
      end else begin
         cfg_pulse <= rise_vec[2];
      end
   end

   // Auto-repeat engines: g = 1 is increment, g = 0 is decrement; each
   // watches the other's debounced level for the mutual lock-out.
   for (genvar g = 0; g < 2; g++) begin : g_rpt
      localparam int OTHER = (g == 1) ? 0 : 1;

      rpt_state_t    state;
      logic [TW-1:0] timer;
      logic          pulse;

      always_ff @(posedge clock or negedge reset_i) begin
         if (!reset_i) begin
            state <= ST_IDLE;
            timer <= '0;
            pulse <= 1'b0;
         end else begin
            pulse <= 1'b0;
            // Release wins over everything, including a timer expiring now.
            if (!stable_vec[g]) begin
               state <= ST_IDLE;
               timer <= '0;
            end else if (stable_vec[OTHER]) begin
               // Both held (also covers a simultaneous rise): lock out
               // until this button is released and pressed again.
               state <= ST_LOCK;
               timer <= '0;
            end else begin
               case (state)
                  ST_IDLE: begin
                     if (rise_vec[g]) begin
                        pulse <= 1'b1;
                        state <= ST_HOLD;
                        timer <= '0;
                     end
                  end
                  ST_HOLD: begin
                     if (timer == HOLD_LAST) begin
                        pulse <= 1'b1;
                        state <= ST_REPEAT;
                        timer <= '0;
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
                  ST_REPEAT: begin
                     if (timer == REPEAT_LAST) begin
                        pulse <= 1'b1;
                        timer <= '0;
                     end else begin
                        timer <= timer + TW'(1);
                     end
                  end
                  default: begin
                     state <= ST_LOCK;
                  end
               endcase
            end
         end
      end
   end

   assign config_pulse_o = cfg_pulse;
   assign inc_pulse_o    = g_rpt[1].pulse;
   assign dec_pulse_o    = g_rpt[0].pulse;
   assign btn_level_o    = stable_vec;

endmodule

// File: tb/tb_button_event_gen.sv
`timescale 1ns/1ps
module tb_button_event_gen;

   localparam int DB = 4;
   localparam int HD = 20;
   localparam int RP = 5;

   logic       clock = 1'b0;
   logic       reset_i = 1'b0;
   logic       config_i = 1'b0;
   logic       increment_i = 1'b0;
   logic       decrement_i = 1'b0;
   logic       config_pulse_o;
   logic       inc_pulse_o;
   logic       dec_pulse_o;
   logic [2:0] btn_level_o;

   button_event_gen #(
      .DEBOUNCE_CYCLES(DB),
      .HOLD_CYCLES    (HD),
      .REPEAT_CYCLES  (RP)
   ) dut (
      .clock         (clock),
      .reset_i       (reset_i),
      .config_i      (config_i),
      .increment_i   (increment_i),
      .decrement_i   (decrement_i),
      .config_pulse_o(config_pulse_o),
      .inc_pulse_o   (inc_pulse_o),
      .dec_pulse_o   (dec_pulse_o),
      .btn_level_o   (btn_level_o)
   );

   always #5 clock = ~clock;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Pulse / level-rise logs (cycle numbers) for DUT and model.
   int dq_cfg[$], dq_inc[$], dq_dec[$];
   int mq_cfg[$], mq_inc[$], mq_dec[$];
   int lvl_q[$];
   int none[$];

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   initial forever begin
      @(posedge clock);
      cyc++;
   end

   // ---------------- behavioural model ----------------
   // Raw input is seen through a 2-cycle delay line; a debounced level
   // flips once the delayed input has disagreed with it for DB+1 cycles
   // in a row. Press pulses follow the level's rise by one cycle; repeat
   // pulses land at press + HD + j*RP while the button stays held alone.
   logic [2:0] m_d0 = '0, m_d1 = '0;
   logic [2:0] m_stab = '0, m_prev = '0;
   int         m_run[3];
   int         m_t = 0;
   bit         m_act[2], m_lock[2];
   int         m_press[2];
   logic       e_cfg = 1'b0, e_inc = 1'b0, e_dec = 1'b0;

   initial forever begin
      logic [2:0] rise;
      logic [2:0] nstab;
      logic [1:0] pl;
      @(posedge clock or negedge reset_i);
      if (!reset_i) begin
         m_d0 = '0; m_d1 = '0; m_stab = '0; m_prev = '0;
         for (int b = 0; b < 3; b++) m_run[b] = 0;
         for (int i = 0; i < 2; i++) begin m_act[i] = 0; m_lock[i] = 0; end
         e_cfg = 0; e_inc = 0; e_dec = 0;
      end else begin
         m_t++;
         rise = m_stab & ~m_prev;
         e_cfg = rise[2];
         pl = '0;
         for (int i = 0; i < 2; i++) begin
            bit own, oth;
            own = m_stab[i];
            oth = m_stab[1 - i];
            if (!own) begin
               m_act[i] = 0; m_lock[i] = 0;
            end else if (oth) begin
               m_act[i] = 0; m_lock[i] = 1;
            end else if (!m_act[i] && !m_lock[i]) begin
               if (rise[i]) begin
                  pl[i] = 1; m_act[i] = 1; m_press[i] = m_t;
               end
            end else if (m_act[i]) begin
               int k;
               k = m_t - m_press[i];
               if (k >= HD && ((k - HD) % RP) == 0) pl[i] = 1;
            end
         end
         e_inc = pl[1];
         e_dec = pl[0];
         nstab = m_stab;
         for (int b = 0; b < 3; b++) begin
            if (m_d1[b] != m_stab[b]) begin
               m_run[b]++;
               if (m_run[b] == DB + 1) begin
                  nstab[b] = m_d1[b];
                  m_run[b] = 0;
               end
            end else begin
               m_run[b] = 0;
            end
         end
         m_prev = m_stab;
         m_stab = nstab;
         m_d1 = m_d0;
         m_d0 = {config_i, increment_i, decrement_i};
      end
   end

   // ---------------- per-cycle compare + logging ----------------
   initial begin
      logic lvl_prev;
      lvl_prev = 1'b0;
      forever begin
         @(negedge clock);
         chk("cfg_pulse", config_pulse_o, e_cfg);
         chk("inc_pulse", inc_pulse_o, e_inc);
         chk("dec_pulse", dec_pulse_o, e_dec);
         chk("btn_level", btn_level_o, m_stab);
         if (config_pulse_o) dq_cfg.push_back(cyc);
         if (inc_pulse_o)    dq_inc.push_back(cyc);
         if (dec_pulse_o)    dq_dec.push_back(cyc);
         if (e_cfg) mq_cfg.push_back(cyc);
         if (e_inc) mq_inc.push_back(cyc);
         if (e_dec) mq_dec.push_back(cyc);
         if (btn_level_o[2] && !lvl_prev) lvl_q.push_back(cyc);
         lvl_prev = btn_level_o[2];
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Compare pulses (relative to start) inside [start, stop) against a
   // hand-computed list, for both the DUT log and the model log.
   task automatic check_pulses(input string nm, input int sel, input int start,
                               input int stop, input int exp[$]);
      int src[$];
      int got[$];
      for (int k = 0; k < 2; k++) begin
         got.delete();
         case (sel)
            0: src = (k == 0) ? dq_cfg : mq_cfg;
            1: src = (k == 0) ? dq_inc : mq_inc;
            2: src = (k == 0) ? dq_dec : mq_dec;
            default: src = lvl_q;
         endcase
         foreach (src[j]) if (src[j] >= start && src[j] < stop) got.push_back(src[j] - start);
         chk({nm, (k == 0) ? "_count" : "_model_count"}, got.size(), exp.size());
         for (int j = 0; j < got.size() && j < exp.size(); j++)
            chk({nm, (k == 0) ? "_time" : "_model_time"}, got[j], exp[j]);
      end
   endtask

   initial begin
      int s, s2, e[$];
      int rem[3];
      logic [2:0] lv;

      // Reset state
      tick(3);
      chk("reset_cfg", config_pulse_o, 0);
      chk("reset_inc", inc_pulse_o, 0);
      chk("reset_dec", dec_pulse_o, 0);
      chk("reset_level", btn_level_o, 0);
      reset_i = 1'b1;
      tick(5);

      // Clean config press
      config_i = 1; s = cyc + 1;
      tick(30);
      config_i = 0;
      tick(15);
      e = '{7};
      check_pulses("cfg_press", 0, s, cyc, e);
      e = '{6};
      check_pulses("cfg_level_rise", 3, s, cyc, e);

      // Increment held 50 cycles
      increment_i = 1; s = cyc + 1;
      tick(50);
      increment_i = 0;
      tick(15);
      e = '{7, 27, 32, 37, 42, 47, 52};
      check_pulses("inc_hold", 1, s, cyc, e);

      // Bounce, then steady
      s2 = cyc + 1;
      for (int r = 0; r < 3; r++) begin
         increment_i = 1; tick(2);
         increment_i = 0; tick(1);
      end
      increment_i = 1; s = cyc + 1;
      tick(15);
      increment_i = 0;
      tick(15);
      e = '{7 + s - s2};
      check_pulses("bounce", 1, s2, cyc, e);

      // Inc into REPEAT, then dec pressed -> lock
      increment_i = 1; s = cyc + 1;
      tick(33);
      decrement_i = 1;
      tick(20);
      decrement_i = 0;
      tick(20);
      increment_i = 0;
      tick(15);
      e = '{7, 27, 32, 37};
      check_pulses("lock_inc", 1, s, cyc, e);
      check_pulses("lock_dec", 2, s, cyc, none);
      increment_i = 1; s = cyc + 1;
      tick(12);
      increment_i = 0;
      tick(12);
      e = '{7};
      check_pulses("repress_inc", 1, s, cyc, e);

      // Simultaneous inc/dec rise
      increment_i = 1; decrement_i = 1; s = cyc + 1;
      tick(40);
      increment_i = 0; decrement_i = 0;
      tick(15);
      check_pulses("simul_inc", 1, s, cyc, none);
      check_pulses("simul_dec", 2, s, cyc, none);

      // Reset mid-REPEAT with inc held
      increment_i = 1; s = cyc + 1;
      tick(38);
      chk("pre_reset_pulse", inc_pulse_o, 1);
      #2 reset_i = 1'b0;
      #1;
      chk("async_reset_inc", inc_pulse_o, 0);
      chk("async_reset_level", btn_level_o, 0);
      tick(3);
      reset_i = 1'b1; s2 = cyc + 1;
      tick(40);
      increment_i = 0;
      tick(15);
      e = '{7, 27, 32, 37};
      check_pulses("before_reset", 1, s, s2, e);
      e = '{7, 27, 32, 37, 42};
      check_pulses("after_reset", 1, s2, cyc, e);

      // Randomised phase, model-checked every cycle
      for (int b = 0; b < 3; b++) rem[b] = 0;
      lv = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int b = 0; b < 3; b++) begin
            if (rem[b] == 0) begin
               lv[b]  = 1'($urandom_range(0, 1));
               rem[b] = $urandom_range(1, 40);
            end
            rem[b]--;
         end
         {config_i, increment_i, decrement_i} = lv;
         tick(1);
      end
      {config_i, increment_i, decrement_i} = 3'b000;
      tick(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
